// File: rtl/neuron_accumulator.sv
// Purpose: sums N_INPUTS signed x*w products plus a bias and flags cat (sum > 0).
// Latency: result_valid rises two cycles after the final product handshake.
// Backpressure: prod_ready is high only while accumulating; the result holds until result_ready.
module neuron_accumulator #(
    parameter int N_INPUTS = 12288,
    parameter int PROD_W   = 32,
    parameter int ACC_W    = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROD_W-1:0] bias,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ACC_W-1:0]  result_sum,
    output logic              is_cat,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [PROD_W-1:0]   bias_q, bias_d;

    logic [PROD_W-1:0]   addend;
    logic [ACC_W:0]      sum_wide;
    logic                clamp;
    logic [ACC_W-1:0]    sum_sat;
    logic                handshake;

    // One shared saturating adder: the bias reuses the product datapath in BIAS.
    always_comb begin
        addend   = (state_q == S_BIAS) ? bias_q : prod_data;
        sum_wide = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W+1-PROD_W){addend[PROD_W-1]}}, addend};
        // The two top bits disagree only when the true sum left the ACC_W range.
        clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (!clamp) begin
            sum_sat = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            sum_sat = ACC_MIN;
        end else begin
            sum_sat = ACC_MAX;
        end
    end

    assign handshake = prod_valid && (state_q == S_ACCUM);

    // Next-state and datapath updates for the classification sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        bias_d  = bias_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    bias_d  = bias;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (handshake) begin
                    acc_d = sum_sat;
                    ovf_d = ovf_q | clamp;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_BIAS;
                    end
                end
            end
            S_BIAS: begin
                acc_d   = sum_sat;
                ovf_d   = ovf_q | clamp;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            bias_q  <= bias_d;
        end
    end

    // Result outputs track the accumulator, so they hold in IDLE until the next start.
    always_comb begin
        prod_ready   = (state_q == S_ACCUM);
        result_valid = (state_q == S_DONE);
        busy         = (state_q != S_IDLE);
        result_sum   = acc_q;
        is_cat       = !acc_q[ACC_W-1] && (acc_q != '0);
        overflow     = ovf_q;
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Purpose: drives two accumulators (48-bit and 33-bit) with identical traffic and checks both.
// Latency: checks the two-cycle result latency and DONE hold / release timing.
// Backpressure: stray products outside ACCUM and stalled result_ready are exercised.
module tb_neuron_accumulator;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bias = '0;
    logic        prod_valid = 1'b0;
    logic [31:0] prod_data = '0;
    logic        result_ready = 1'b0;

    logic        pr_a, rv_a, cat_a, ov_a, busy_a;
    logic [47:0] sum_a;
    logic        pr_b, rv_b, cat_b, ov_b, busy_b;
    logic [32:0] sum_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_accumulator #(.N_INPUTS(N), .PROD_W(32), .ACC_W(48)) dut_a (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .prod_valid(prod_valid), .prod_ready(pr_a), .prod_data(prod_data),
        .result_valid(rv_a), .result_ready(result_ready), .result_sum(sum_a),
        .is_cat(cat_a), .overflow(ov_a), .busy(busy_a)
    );

    neuron_accumulator #(.N_INPUTS(N), .PROD_W(32), .ACC_W(33)) dut_b (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .prod_valid(prod_valid), .prod_ready(pr_b), .prod_data(prod_data),
        .result_valid(rv_b), .result_ready(result_ready), .result_sum(sum_b),
        .is_cat(cat_b), .overflow(ov_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: fold products then bias into a w-bit saturating sum.
    function automatic void model(input int prods[$], input int b, input int w,
                                  output longint s, output bit ov);
        longint one = 1;
        longint mx = (one << (w - 1)) - 1;
        longint mn = -(one << (w - 1));
        int     terms[$];
        terms = prods;
        terms.push_back(b);
        s  = 0;
        ov = 1'b0;
        foreach (terms[i]) begin
            s = s + longint'(terms[i]);
            if (s > mx) begin
                s = mx; ov = 1'b1;
            end else if (s < mn) begin
                s = mn; ov = 1'b1;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdy"},  pr_a, 0);
        chk({tag, "_rv"},   rv_a, 0);
        chk({tag, "_sum"},  longint'($signed(sum_a)), 0);
        chk({tag, "_cat"},  cat_a, 0);
        chk({tag, "_ovf"},  ov_b, 0);
        chk({tag, "_busy"}, busy_a, 0);
    endtask

    // One full classification; stray products in IDLE/DONE and stray starts are injected.
    task automatic run(input int b, input int prods[$], input int gap_max, input int hold);
        longint ea, eb;
        bit     oa, ob;
        longint held;
        model(prods, b, 48, ea, oa);
        model(prods, b, 33, eb, ob);

        prod_valid = 1'b1;
        prod_data  = 32'h7FFF_0000;
        step();
        chk("idle_rdy", pr_a, 0);

        start      = 1'b1;
        bias       = b;
        prod_valid = 1'b0;
        step();
        start = 1'b0;
        chk("start_busy", busy_a, 1);
        chk("start_rdy", pr_b, 1);
        chk("start_ovf_clr", ov_b, 0);

        foreach (prods[i]) begin
            repeat ($urandom_range(gap_max, 0)) begin
                start = 1'($urandom_range(1, 0));
                step();
            end
            start      = 1'b0;
            prod_valid = 1'b1;
            prod_data  = prods[i];
            step();
            prod_valid = 1'b0;
        end

        chk("lat_bias_rv", rv_a, 0);
        chk("lat_bias_rdy", pr_a, 0);
        step();
        chk("lat_done_rv_a", rv_a, 1);
        chk("lat_done_rv_b", rv_b, 1);
        chk("sum_a", longint'($signed(sum_a)), ea);
        chk("sum_b", longint'($signed(sum_b)), eb);
        chk("cat_a", cat_a, longint'(ea > 0));
        chk("cat_b", cat_b, longint'(eb > 0));
        chk("ovf_a", ov_a, longint'(oa));
        chk("ovf_b", ov_b, longint'(ob));

        held = longint'($signed(sum_a));
        for (int h = 0; h < hold; h++) begin
            start      = (h == hold / 2);
            prod_valid = 1'b1;
            prod_data  = 32'h0000_1234;
            step();
            chk("hold_rv", rv_a, 1);
            chk("hold_rdy", pr_a, 0);
            chk("hold_sum", longint'($signed(sum_a)), held);
        end
        prod_valid   = 1'b0;
        start        = 1'b1;
        result_ready = 1'b1;
        step();
        start        = 1'b0;
        result_ready = 1'b0;
        chk("rel_rv", rv_a, 0);
        chk("rel_busy", busy_a, 0);
        chk("rel_sum_kept", longint'($signed(sum_b)), eb);
        chk("rel_ovf_kept", ov_b, longint'(ob));
        step();
        chk("idle_no_start", busy_b, 0);
    endtask

    initial begin
        int q[$];

        #3;
        check_all_zero("rst_hold");
        step();
        rst = 1'b0;
        step();
        check_all_zero("rst_rel");

        q = {100, -20, 5, 3};
        run(-10, q, 0, 0);

        q = {1, 2, 3, 4};
        run(-10, q, 3, 0);

        q = {7, -7, 9, 11};
        run(5, q, 2, 5);

        q = {int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF)};
        run(0, q, 1, 0);

        q = {int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000)};
        run(0, q, 0, 1);

        // Reset in the middle of a run discards the partial sum.
        start = 1'b1;
        bias  = 32'd50;
        step();
        start      = 1'b0;
        prod_valid = 1'b1;
        prod_data  = 32'd1000;
        step();
        step();
        prod_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check_all_zero("mid_rst_rel");
        q = {1, 1, 1, 1};
        run(0, q, 0, 0);

        for (int r = 0; r < 8; r++) begin
            q = {};
            for (int k = 0; k < N; k++) begin
                q.push_back(int'($urandom()));
            end
            run(int'($urandom()), q, 3, int'($urandom_range(3, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
